board_tile_store: RTL and testbench

Holds the 4x4 sliding-puzzle tile array and applies the tile moves requested by the game-board FSM; it is the consumer end of the `moveFrom`/`moveTo` interface. Each accepted move is validated, the moving tile is written into the empty cell, and the board is scanned to refresh the solved flag. A registered read port serves the VGA draw logic.

---
 rtl/puzzle_pkg.sv | 22 ++
 rtl/tile_adjacency_check.sv | 26 ++
 rtl/board_tile_store.sv | 109 ++++++++++
 tb/tb_board_tile_store.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared constants, FSM state type and solved-board pattern for the 4x4 sliding puzzle.
package puzzle_pkg;

  localparam int POS_W     = 5;
  localparam int TILE_W    = 4;
  localparam int BOARD_DIM = 4;
  localparam int N_CELLS   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VALIDATE,
    S_APPLY,
    S_SCAN,
    S_ERR
  } state_t;

  // Tile that belongs at position p (1..16) in the solved arrangement; last cell is empty.
  function automatic logic [TILE_W-1:0] expected(input logic [POS_W-1:0] p);
    return (p == POS_W'(N_CELLS)) ? '0 : p[TILE_W-1:0];
  endfunction

endpackage

// File: rtl/tile_adjacency_check.sv
// Combinational legality check for a move: range, inequality and row-aware adjacency.
module tile_adjacency_check
  import puzzle_pkg::*;
(
  input  logic [POS_W-1:0] from,
  input  logic [POS_W-1:0] to,
  output logic             legal
);

  logic             in_range;
  logic [POS_W-1:0] from_m1;
  logic [POS_W-1:0] to_m1;
  logic [POS_W-1:0] diff;
  logic             same_row;

  assign in_range = (from >= POS_W'(1)) && (from <= POS_W'(N_CELLS)) &&
                    (to   >= POS_W'(1)) && (to   <= POS_W'(N_CELLS));
  assign from_m1  = from - POS_W'(1);
  assign to_m1    = to - POS_W'(1);
  assign diff     = (from > to) ? (from - to) : (to - from);
  // Row index is bits [3:2] of the zero-based position; only meaningful when in range.
  assign same_row = (from_m1[3:2] == to_m1[3:2]);
  assign legal    = in_range &&
                    ((diff == POS_W'(BOARD_DIM)) || ((diff == POS_W'(1)) && same_row));

endmodule

// File: rtl/board_tile_store.sv
// Sliding-puzzle tile array: validates and applies moves, rescans for solved, serves a read port.
module board_tile_store #(
  parameter int N_CELLS = 16,
  parameter int CNT_W   = 10
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         move_valid,
  input  logic [puzzle_pkg::POS_W-1:0] move_from,
  input  logic [puzzle_pkg::POS_W-1:0] move_to,
  output logic                         move_ready,
  output logic                         move_done,
  output logic                         move_err,
  input  logic [3:0]                   rd_addr,
  output logic [3:0]                   rd_tile,
  output logic                         solved,
  output logic [CNT_W-1:0]             move_count
);
  import puzzle_pkg::*;

  state_t            state, state_nx;
  logic [TILE_W-1:0] tiles [N_CELLS];
  logic [POS_W-1:0]  from_q, to_q;
  logic [3:0]        from_idx, to_idx;
  logic [3:0]        scan_idx;
  logic              mismatch_q;
  logic              solved_q;
  logic              done_q;
  logic [CNT_W-1:0]  count_q;
  logic [TILE_W-1:0] rd_q;
  logic              adj_legal;
  logic              scan_last;
  logic              scan_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  tile_adjacency_check u_adj (
    .from  (from_q),
    .to    (to_q),
    .legal (adj_legal)
  );

  // Array is stored zero-based; positions arrive one-based.
  assign from_idx  = 4'(from_q - POS_W'(1));
  assign to_idx    = 4'(to_q - POS_W'(1));
  assign scan_last = (scan_idx == 4'(N_CELLS - 1));
  assign scan_bad  = (tiles[scan_idx] != expected({1'b0, scan_idx} + POS_W'(1)));

  always_comb begin
    state_nx   = state;
    move_ready = 1'b0;
    case (state)
      S_IDLE: begin
        move_ready = 1'b1;
        if (move_valid) state_nx = S_VALIDATE;
      end
      S_VALIDATE: state_nx = (adj_legal && (tiles[to_idx] == '0)) ? S_APPLY : S_ERR;
      S_APPLY:    state_nx = S_SCAN;
      S_SCAN:     if (scan_last) state_nx = S_IDLE;
      S_ERR:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      from_q     <= '0;
      to_q       <= '0;
      scan_idx   <= '0;
      mismatch_q <= 1'b0;
      solved_q   <= 1'b1;
      done_q     <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      for (int i = 0; i < N_CELLS; i++) tiles[i] <= expected(POS_W'(i + 1));
    end else begin
      state  <= state_nx;
      done_q <= (state == S_SCAN) && scan_last;
      rd_q   <= tiles[rd_addr];
      if ((state == S_IDLE) && move_valid) begin
        from_q <= move_from;
        to_q   <= move_to;
      end
      if (state == S_APPLY) begin
        tiles[to_idx]   <= tiles[from_idx];
        tiles[from_idx] <= '0;
        count_q         <= sat_inc(count_q);
        scan_idx        <= '0;
        mismatch_q      <= 1'b0;
      end
      // Solved is committed only once the whole board has been scanned.
      if (state == S_SCAN) begin
        mismatch_q <= mismatch_q | scan_bad;
        scan_idx   <= scan_idx + 4'd1;
        if (scan_last) solved_q <= !(mismatch_q | scan_bad);
      end
    end
  end

  assign move_done  = done_q;
  assign move_err   = (state == S_ERR);
  assign rd_tile    = rd_q;
  assign solved     = solved_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_board_tile_store.sv
// Randomized self-checking bench for board_tile_store against a grid-level puzzle model.
module tb_board_tile_store;

  logic       clk = 1'b0;
  logic       resetn;
  logic       move_valid;
  logic [4:0] move_from, move_to;
  logic       move_ready, move_done, move_err;
  logic [3:0] rd_addr, rd_tile;
  logic       solved;
  logic [9:0] move_count;

  int n_tests = 0;
  int n_fail  = 0;

  int bd [1:16];
  int m_count;
  int m_solved;

  always #5 clk = ~clk;

  board_tile_store #(.N_CELLS(16), .CNT_W(10)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .move_valid (move_valid),
    .move_from  (move_from),
    .move_to    (move_to),
    .move_ready (move_ready),
    .move_done  (move_done),
    .move_err   (move_err),
    .rd_addr    (rd_addr),
    .rd_tile    (rd_tile),
    .solved     (solved),
    .move_count (move_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 1; p <= 16; p++) bd[p] = (p == 16) ? 0 : p;
    m_count  = 0;
    m_solved = 1;
  endfunction

  function automatic int model_is_solved();
    for (int p = 1; p <= 16; p++)
      if (bd[p] != ((p == 16) ? 0 : p)) return 0;
    return 1;
  endfunction

  function automatic int model_legal(input int f, input int t);
    int dr, dc;
    if (f < 1 || f > 16 || t < 1 || t > 16) return 0;
    if (bd[t] != 0) return 0;
    dr = (f - 1) / 4 - (t - 1) / 4;
    dc = (f - 1) % 4 - (t - 1) % 4;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    return (dr + dc == 1) ? 1 : 0;
  endfunction

  task automatic reset_dut(input bit check);
    @(negedge clk);
    resetn     = 1'b0;
    move_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    if (check) begin
      chk("reset_solved", solved, 1);
      chk("reset_count", move_count, 0);
      chk("reset_ready", move_ready, 1);
      chk("reset_done", move_done, 0);
      chk("reset_err", move_err, 0);
      chk("reset_rd_tile", rd_tile, 0);
    end
    resetn = 1'b1;
  endtask

  task automatic read_board();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("board_pos%0d", a + 1), rd_tile, bd[a + 1]);
    end
  endtask

  task automatic do_move(input int f, input int t, input bit full);
    int legal, moved, old_solved;
    int first_done, first_err, n_done, n_err;
    legal      = model_legal(f, t);
    moved      = (legal != 0) ? bd[f] : 0;
    old_solved = m_solved;
    first_done = -1;
    first_err  = -1;
    n_done     = 0;
    n_err      = 0;
    @(negedge clk);
    if (full) chk("ready_before_move", move_ready, 1);
    move_valid = 1'b1;
    move_from  = 5'(f);
    move_to    = 5'(t);
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (move_done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (move_err) begin
        n_err++;
        if (first_err < 0) first_err = c;
      end
      if (full && c == 10) chk("solved_held", solved, old_solved);
      if (full && legal != 0 && c == 2) rd_addr = 4'(t - 1);
      if (full && legal != 0 && c == 3) chk("rd_before_write", rd_tile, 0);
      if (full && legal != 0 && c == 4) chk("rd_after_write", rd_tile, moved);
      @(negedge clk);
    end
    if (legal != 0) begin
      bd[t]    = bd[f];
      bd[f]    = 0;
      if (m_count < 1023) m_count++;
      m_solved = model_is_solved();
      chk($sformatf("done_cycle_%0d_%0d", f, t), first_done, 19);
      chk("done_pulses", n_done, 1);
      chk("err_pulses_on_legal", n_err, 0);
    end else begin
      chk($sformatf("err_cycle_%0d_%0d", f, t), first_err, 2);
      chk("err_pulses", n_err, 1);
      chk("done_pulses_on_reject", n_done, 0);
    end
    chk("move_count", move_count, m_count);
    chk("solved", solved, m_solved);
    if (full) read_board();
  endtask

  task automatic random_move();
    int e, n, f, t, dir;
    if ($urandom_range(1, 0) == 1) begin
      e = 1;
      for (int p = 1; p <= 16; p++) if (bd[p] == 0) e = p;
      n = 0;
      while (n == 0) begin
        dir = $urandom_range(3, 0);
        case (dir)
          0: n = (e > 4)         ? e - 4 : 0;
          1: n = (e < 13)        ? e + 4 : 0;
          2: n = ((e - 1) % 4 != 0) ? e - 1 : 0;
          default: n = ((e - 1) % 4 != 3) ? e + 1 : 0;
        endcase
      end
      f = n;
      t = e;
    end else begin
      f = $urandom_range(17, 0);
      t = $urandom_range(17, 0);
    end
    do_move(f, t, 1'b1);
  endtask

  task automatic held_valid_reset();
    int n_pulse;
    @(negedge clk);
    move_valid = 1'b1;
    move_from  = 5'd15;
    move_to    = 5'd16;
    @(posedge clk);
    @(negedge clk);
    move_from = 5'd16;
    move_to   = 5'd15;
    for (int c = 1; c <= 30; c++) begin
      if (c == 19) begin
        chk("b2b_done", move_done, 1);
        chk("b2b_ready", move_ready, 1);
      end
      if (c == 20) chk("b2b_accepted", move_ready, 0);
      if (c == 30) begin
        resetn     = 1'b0;
        move_valid = 1'b0;
      end
      if (c < 30) @(negedge clk);
    end
    @(negedge clk);
    model_reset();
    chk("midreset_ready", move_ready, 1);
    chk("midreset_done", move_done, 0);
    chk("midreset_err", move_err, 0);
    chk("midreset_count", move_count, 0);
    chk("midreset_solved", solved, 1);
    resetn  = 1'b1;
    n_pulse = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (move_done || move_err) n_pulse++;
    end
    chk("midreset_no_pulse", n_pulse, 0);
    read_board();
  endtask

  initial begin
    resetn     = 1'b0;
    move_valid = 1'b0;
    move_from  = '0;
    move_to    = '0;
    rd_addr    = '0;
    model_reset();

    reset_dut(1'b1);
    read_board();

    do_move(12, 16, 1'b1);

    reset_dut(1'b0);
    do_move(15, 16, 1'b1);
    do_move(16, 15, 1'b1);

    do_move(4, 5, 1'b1);
    do_move(10, 16, 1'b1);
    do_move(0, 16, 1'b1);

    for (int i = 0; i < 40; i++) random_move();

    reset_dut(1'b0);
    held_valid_reset();

    reset_dut(1'b0);
    for (int i = 0; i < 1022; i++) begin
      if (i % 2 == 0) do_move(15, 16, 1'b0);
      else            do_move(16, 15, 1'b0);
    end
    chk("count_at_1022", move_count, 1022);
    do_move(15, 16, 1'b1);
    do_move(16, 15, 1'b1);
    do_move(15, 16, 1'b1);
    chk("count_saturated", move_count, 1023);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
